bg_noise_estimator: RTL

Computes the per-lane background-noise estimate that the noise-removal stage subtracts from each period. The block accumulates 2^LOG2_PERIODS noise-only periods of 16 signed 8-bit lanes, then divides each lane sum by the period count to form the mean. It publishes the means as 16 signed 16-bit lanes on a packed 256-bit bus, and holds that bus stable until the next estimate completes. It sits directly upstream of the noise-removal stage and drives that stage's background-noise input.

---
 rtl/bg_noise_estimator.sv | 107 ++++++++++
 1 files changed

// File: rtl/bg_noise_estimator.sv
// Per-lane background-noise estimator: averages 2^LOG2_PERIODS noise-only periods
// of signed 8-bit lanes and publishes the floor-mean as signed 16-bit lanes.
module bg_noise_estimator #(
  parameter int unsigned LOG2_PERIODS = 4,
  parameter int unsigned LANES        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  period_valid,
  input  logic [8*LANES-1:0]    period_data,
  output logic [16*LANES-1:0]   bg_noise,
  output logic                  bg_noise_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned AccW = 8 + LOG2_PERIODS;
  localparam int unsigned CntW = LOG2_PERIODS + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((1 << LOG2_PERIODS) - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccum  = 2'd1;
  localparam logic [1:0] StDivide = 2'd2;

  logic [1:0]             state_q, state_d;
  logic signed [AccW-1:0] acc_q [LANES];
  logic signed [AccW-1:0] acc_d [LANES];
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [16*LANES-1:0]    bg_q, bg_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bg_d    = bg_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    // start wins in every state: it clears the running sums and drops the current sample
    if (start) begin
      state_d = StAccum;
      cnt_d   = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        acc_d[i] = '0;
      end
    end else begin
      case (state_q)
        StIdle: ;
        StAccum: begin
          if (period_valid) begin
            for (int unsigned i = 0; i < LANES; i++) begin
              acc_d[i] = acc_q[i] + AccW'($signed(period_data[8*i +: 8]));
            end
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
              state_d = StDivide;
            end
          end
        end
        StDivide: begin
          // Arithmetic shift gives the floor of the mean; result always fits in 8 bits
          for (int unsigned i = 0; i < LANES; i++) begin
            bg_d[16*i +: 16] = 16'(acc_q[i] >>> LOG2_PERIODS);
          end
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bg_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bg_q    <= bg_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int unsigned i = 0; i < LANES; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign bg_noise       = bg_q;
  assign bg_noise_valid = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
